// File: rtl/data_memory.sv
// Word-addressable data memory: combinational read, synchronous write, synchronous clear.
// Define DATA_MEMORY_BOUNDS_CHECK_EN to reject out-of-range addresses; otherwise upper bits wrap.
module data_memory #(
   parameter int DEPTH = 64,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          write,
   input  logic [AW-1:0] address,
   input  logic [DW-1:0] write_data,
   output logic [DW-1:0] read_data
);

   localparam int IW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [IW-1:0] word_index;
   logic [AW-1:0] upper_bits;
   logic          in_range;
   logic          unused_addr_bits;

   assign word_index = address[IW+1:2];
   assign upper_bits = address >> (IW + 2);

`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
   assign in_range = (upper_bits == '0);
`else
   assign in_range = 1'b1;
`endif

   // Byte-offset bits never select anything; upper bits only matter with bounds checking.
   assign unused_addr_bits = ^{address[1:0], upper_bits};

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (write && in_range) begin
         mem[word_index] <= write_data;
      end
   end

   assign read_data = in_range ? mem[word_index] : '0;

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory (DEPTH=64).
module tb_data_memory;

   logic        clk;
   logic        reset;
   logic        write;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;

   int checks;
   int errors;

   data_memory #(.DEPTH(64), .AW(32), .DW(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .write      (write),
      .address    (address),
      .write_data (write_data),
      .read_data  (read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d);
      address    = a;
      write_data = d;
      write      = 1'b1;
      tick();
      write      = 1'b0;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
      address = a;
      #1;
      checks++;
      if (read_data !== exp) begin
         errors++;
         $display("[TB] FAIL %s addr=%0d got=%h expected=%h", name, a, read_data, exp);
      end
   endtask

   task automatic test_reset;
      do_reset();
      do_write(32'd0, 32'hAAAA_0001);
      do_write(32'd4, 32'hAAAA_0002);
      do_write(32'd252, 32'hAAAA_0003);
      read_check("pre_reset_252", 32'd252, 32'hAAAA_0003);
      do_reset();
      read_check("reset_0", 32'd0, 32'h0);
      read_check("reset_4", 32'd4, 32'h0);
      read_check("reset_252", 32'd252, 32'h0);
   endtask

   task automatic test_basic;
      do_write(32'd8, 32'd12345);
      read_check("basic_8", 32'd8, 32'd12345);
      read_check("basic_12", 32'd12, 32'h0);
   endtask

   task automatic test_overwrite;
      do_write(32'd16, 32'd7);
      do_write(32'd16, 32'd99);
      address = 32'd16;
      for (int i = 0; i < 3; i++) begin
         tick();
         read_check("persist_16", 32'd16, 32'd99);
      end
   endtask

   task automatic test_misaligned;
      do_write(32'd20, 32'hDEAD_BEEF);
      read_check("misalign_21", 32'd21, 32'hDEAD_BEEF);
      read_check("misalign_22", 32'd22, 32'hDEAD_BEEF);
      read_check("misalign_23", 32'd23, 32'hDEAD_BEEF);
      do_write(32'd27, 32'h0000_5A5A);
      read_check("misalign_wr_24", 32'd24, 32'h0000_5A5A);
   endtask

   task automatic test_read_during_write;
      do_write(32'd28, 32'h1111_1111);
      address    = 32'd28;
      write_data = 32'h2222_2222;
      write      = 1'b1;
      #1;
      checks++;
      if (read_data !== 32'h1111_1111) begin
         errors++;
         $display("[TB] FAIL rdw_old got=%h expected=%h", read_data, 32'h1111_1111);
      end
      tick();
      write = 1'b0;
      checks++;
      if (read_data !== 32'h2222_2222) begin
         errors++;
         $display("[TB] FAIL rdw_new got=%h expected=%h", read_data, 32'h2222_2222);
      end
   endtask

   task automatic test_back_to_back;
      do_write(32'd32, 32'h0000_0032);
      do_write(32'd36, 32'h0000_0036);
      do_write(32'd40, 32'h0000_0040);
      read_check("b2b_32", 32'd32, 32'h0000_0032);
      read_check("b2b_36", 32'd36, 32'h0000_0036);
      read_check("b2b_40", 32'd40, 32'h0000_0040);
      read_check("b2b_44", 32'd44, 32'h0);
   endtask

   task automatic test_reset_priority;
      do_write(32'd24, 32'h0000_0123);
      address    = 32'd24;
      write_data = 32'd55;
      write      = 1'b1;
      reset      = 1'b1;
      tick();
      write = 1'b0;
      reset = 1'b0;
      read_check("rst_wins_24", 32'd24, 32'h0);
      read_check("rst_clears_8", 32'd8, 32'h0);
      read_check("rst_clears_20", 32'd20, 32'h0);
   endtask

   task automatic test_out_of_range;
      do_write(32'd0, 32'h0000_0011);
      do_write(32'd256, 32'd77);
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
      read_check("oor_256", 32'd256, 32'h0);
      read_check("oor_0", 32'd0, 32'h0000_0011);
`else
      read_check("alias_0", 32'd0, 32'd77);
      read_check("alias_256", 32'd256, 32'd77);
`endif
      read_check("alias_4", 32'd4, 32'h0);
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      reset      = 1'b0;
      write      = 1'b0;
      address    = '0;
      write_data = '0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_overwrite();
      test_misaligned();
      test_read_during_write();
      test_back_to_back();
      test_reset_priority();
      test_out_of_range();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
